// File: rtl/prga.sv
// -----------------------------------------------------------------------------
// prga -- RC4 pseudo-random generation stage used as a stream decryptor.
//
// Walks an S-box that has already been initialised and key-scheduled, and
// produces one keystream byte per message byte. The ciphertext memory holds a
// length-prefixed message (ct[0] = L, ct[1..L] = bytes). The result goes to
// the plaintext memory in the same format (pt[0] = L, pt[k] = ct[k] ^ pad_k).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   en / rdy   : start handshake; a run starts when en=1 and rdy=1 at an edge
//   s_addr     : S-box address       s_rddata : S-box read data (1-cycle latency)
//   s_wrdata   : S-box write data    s_wren   : S-box write enable
//   ct_addr    : ciphertext address  ct_rddata: ciphertext read data (1-cycle)
//   pt_addr    : plaintext address   pt_wrdata: plaintext write data
//   pt_wren    : plaintext write enable
//
// Memory accesses are decoded from the current state. Read data arrives one
// cycle after the address, so some addresses (RJ) and write data (WI, WP)
// are formed combinationally from the read data of the current cycle.
// -----------------------------------------------------------------------------
module prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE,   // waiting for en
        LEN,    // present ct[0]
        LENW,   // latch L, write pt[0]
        RI,     // i <= i+1, read S[i]
        RJ,     // latch si, j <= j+si, read S[j]
        WI,     // latch sj, S[i] <= sj
        WJ,     // S[j] <= si, present ct[k]
        RP,     // read S[si+sj]
        WP      // pt[k] <= pad ^ ct[k]
    } state_t;

    state_t     state_reg;
    logic [7:0] i_reg;
    logic [7:0] j_reg;
    logic [7:0] k_reg;
    logic [7:0] len_reg;
    logic [7:0] si_reg;
    logic [7:0] sj_reg;

    // -------------------------------------------------------------------------
    // Control FSM and index registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            i_reg     <= 8'd0;
            j_reg     <= 8'd0;
            k_reg     <= 8'd0;
            len_reg   <= 8'd0;
            si_reg    <= 8'd0;
            sj_reg    <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_reg <= LEN;
                    end
                end
                LEN: begin
                    state_reg <= LENW;
                end
                LENW: begin
                    len_reg <= ct_rddata;
                    i_reg   <= 8'd0;
                    j_reg   <= 8'd0;
                    k_reg   <= 8'd1;
                    // An empty message only needs its length byte copied.
                    state_reg <= (ct_rddata == 8'd0) ? IDLE : RI;
                end
                RI: begin
                    i_reg     <= i_reg + 8'd1;
                    state_reg <= RJ;
                end
                RJ: begin
                    si_reg    <= s_rddata;
                    j_reg     <= j_reg + s_rddata;
                    state_reg <= WI;
                end
                WI: begin
                    sj_reg    <= s_rddata;
                    state_reg <= WJ;
                end
                WJ: begin
                    state_reg <= RP;
                end
                RP: begin
                    state_reg <= WP;
                end
                WP: begin
                    if (k_reg == len_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        k_reg     <= k_reg + 8'd1;
                        state_reg <= RI;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory access decode. Everything not driven by the current state stays 0.
    // Write enables are gated by rst so an abort never lands a half-finished
    // swap or plaintext byte on the reset edge.
    // -------------------------------------------------------------------------
    always_comb begin
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state_reg)
            IDLE: begin
                rdy = 1'b1;
            end
            LEN: begin
                ct_addr = 8'd0;
            end
            LENW: begin
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = ~rst;
            end
            RI: begin
                s_addr = i_reg + 8'd1;
            end
            RJ: begin
                s_addr = j_reg + s_rddata;
            end
            WI: begin
                // s_rddata is old S[j]; i_reg already holds the new i.
                s_addr   = i_reg;
                s_wrdata = s_rddata;
                s_wren   = ~rst;
            end
            WJ: begin
                // When i == j this rewrites the same value, leaving S[i] intact.
                s_addr   = j_reg;
                s_wrdata = si_reg;
                s_wren   = ~rst;
                ct_addr  = k_reg;
            end
            RP: begin
                // Uses the registered si/sj, not a re-read of the swapped cells.
                s_addr  = si_reg + sj_reg;
                ct_addr = k_reg;
            end
            WP: begin
                ct_addr   = k_reg;
                pt_addr   = k_reg;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = ~rst;
            end
            default: begin
                rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// -----------------------------------------------------------------------------
// tb_prga -- self-checking bench for prga.
//
// Holds S-box, ciphertext and plaintext memories with one-cycle read latency.
// A software RC4 model pushes the expected plaintext writes into a queue before
// each run; a negedge monitor records every pt write the DUT makes, and the
// main process pops and compares them once the run finishes.
// -----------------------------------------------------------------------------
module tb_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    // ---------------- memories ----------------
    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic       load_s;

    always @(posedge clk) begin
        if (load_s) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end

    // ---------------- write monitor ----------------
    int          s_wr_cnt  = 0;
    int          pt_wr_cnt = 0;
    logic [15:0] obs [4096];

    always @(negedge clk) begin
        if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
        if (pt_wren) begin
            obs[pt_wr_cnt % 4096] <= {pt_addr, pt_wrdata};
            pt_wr_cnt <= pt_wr_cnt + 1;
        end
    end

    // ---------------- model / scoreboard ----------------
    logic [7:0]  m_s [256];
    logic [15:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          rd_ptr   = 0;

    typedef struct {
        int len;
        int key_mode;   // 0: identity S, 1: KSA with key 00 00 18
        int seed;       // ct[k] = seed + 13*(k-1)
        int exp_lat;
        bit mid_en;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic setup(input int len, input int key_mode, input int seed);
        logic [7:0] key [3];
        logic [7:0] t;
        int j;
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
        ct_mem[0] = 8'(len);
        for (int k = 1; k < 256; k++) ct_mem[k] = 8'(seed + 13 * (k - 1));
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        if (key_mode == 1) begin
            j = 0;
            for (int a = 0; a < 256; a++) begin
                j = (j + s_init[a] + key[a % 3]) & 255;
                t = s_init[a]; s_init[a] = s_init[j]; s_init[j] = t;
            end
        end
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        @(negedge clk);
        load_s = 1'b1;
        @(posedge clk);
        #1;
        load_s = 1'b0;
    endtask

    // Reference RC4 PRGA over m_s, queues expected pt writes.
    task automatic model_run(input int len);
        int i, j;
        logic [7:0] t, pad;
        i = 0; j = 0;
        exp_q.push_back({8'd0, 8'(len)});
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) & 255;
            j = (j + m_s[i]) & 255;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            pad = m_s[(m_s[i] + m_s[j]) & 255];
            exp_q.push_back({8'(k), ct_mem[k] ^ pad});
        end
    endtask

    task automatic drain(input string name);
        logic [15:0] o, e;
        while (rd_ptr < pt_wr_cnt) begin
            o = obs[rd_ptr % 4096];
            rd_ptr++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected pt write addr=%02h data=%02h", name, o[15:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s pt write got addr=%02h data=%02h expected addr=%02h data=%02h",
                             name, o[15:8], o[7:0], e[15:8], e[7:0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missing pt write addr=%02h data=%02h", name, e[15:8], e[7:0]);
        end
    endtask

    task automatic check_s(input string name);
        int nbad;
        nbad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) nbad++;
        chk({name, "_sbox_mismatches"}, nbad, 0);
    endtask

    task automatic start_run();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, input bit mid_en, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (mid_en) en = (cnt == 3);
        end while (!rdy && cnt < budget);
        en = 1'b0;
    endtask

    initial begin
        int cnt, sw0, pw0;
        string nm;
        rst = 1'b1; en = 1'b0; load_s = 1'b0;
        for (int a = 0; a < 256; a++) begin
            s_init[a] = 8'(a); ct_mem[a] = 8'd0;
        end

        vecs[0] = '{len: 1,   key_mode: 0, seed: 8'h41, exp_lat: 8,    mid_en: 1'b0};
        vecs[1] = '{len: 0,   key_mode: 0, seed: 8'h10, exp_lat: 2,    mid_en: 1'b0};
        vecs[2] = '{len: 53,  key_mode: 1, seed: 8'h3c, exp_lat: 320,  mid_en: 1'b0};
        vecs[3] = '{len: 5,   key_mode: 1, seed: 8'h99, exp_lat: 32,   mid_en: 1'b1};
        vecs[4] = '{len: 255, key_mode: 0, seed: 8'h07, exp_lat: 1532, mid_en: 1'b0};
        vecs[5] = '{len: 3,   key_mode: 1, seed: 8'hf0, exp_lat: 20,   mid_en: 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", int'(rdy), 1);
        chk("reset_s_wren", int'(s_wren), 0);
        chk("reset_pt_wren", int'(pt_wren), 0);
        chk("reset_addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
        rst = 1'b0;

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            nm = $sformatf("vec%0d_L%0d", v, vecs[v].len);
            setup(vecs[v].len, vecs[v].key_mode, vecs[v].seed);
            model_run(vecs[v].len);
            sw0 = s_wr_cnt;
            start_run();
            wait_rdy(3000, vecs[v].mid_en, cnt);
            chk({nm, "_latency"}, cnt, vecs[v].exp_lat);
            drain(nm);
            check_s(nm);
            chk({nm, "_s_writes"}, s_wr_cnt - sw0, 2 * vecs[v].len);
            $display("run %s latency=%0d", nm, cnt);
            if (v == 0) begin
                chk("single_byte_pt0", int'(pt_mem[0]), 8'h01);
                chk("single_byte_pt1", int'(pt_mem[1]), 8'h43);
            end
        end

        // en held high: two back-to-back runs with one idle cycle between
        setup(2, 1, 8'h55);
        model_run(2);
        model_run(2);
        sw0 = s_wr_cnt;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!rdy && cnt < 100);
        chk("b2b_first_latency", cnt, 14);
        @(posedge clk);
        #1;
        chk("b2b_restart_rdy", int'(rdy), 0);
        en = 1'b0;
        wait_rdy(100, 1'b0, cnt);
        chk("b2b_second_latency", cnt, 14);
        drain("b2b");
        check_s("b2b");
        chk("b2b_s_writes", s_wr_cnt - sw0, 8);
        $display("run b2b done");

        // rst beats en on the same edge
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        chk("rst_prio_rdy", int'(rdy), 1);
        @(posedge clk);
        #1;
        chk("rst_prio_no_start", int'(rdy), 1);
        $display("run rst_priority done");

        // rst in WI of byte 3 aborts the run
        setup(6, 1, 8'h21);
        sw0 = s_wr_cnt;
        pw0 = pt_wr_cnt;
        start_run();
        repeat (16) begin
            @(posedge clk); #1;
        end
        chk("abort_in_wi_s_wren", int'(s_wren), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rdy", int'(rdy), 1);
        chk("abort_wrens", int'(s_wren) + int'(pt_wren), 0);
        chk("abort_addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_s_writes", s_wr_cnt - sw0, 4);
        chk("abort_pt_writes", pt_wr_cnt - pw0, 3);
        chk("abort_stays_idle", int'(rdy), 1);
        rd_ptr = pt_wr_cnt;
        $display("run abort done");

        // Fresh run after abort completes normally
        setup(6, 1, 8'h21);
        model_run(6);
        sw0 = s_wr_cnt;
        pw0 = pt_wr_cnt;
        start_run();
        wait_rdy(3000, 1'b0, cnt);
        chk("post_abort_latency", cnt, 38);
        chk("post_abort_pt_writes", pt_wr_cnt - pw0, 7);
        drain("post_abort");
        check_s("post_abort");
        chk("post_abort_s_writes", s_wr_cnt - sw0, 12);
        $display("run post_abort latency=%0d", cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 en  input  1  start request; honoured only when rdy=1.
REQ-004 rdy  output  1  high = idle and able to accept en.
REQ-005 s_addr  output  8  S-box memory address.
REQ-006 s_rddata  input  8  S-box read data, valid one cycle after s_addr is presented.
REQ-007 s_wrdata  output  8  S-box write data.
REQ-008 s_wren  output  1  S-box write enable.
REQ-009 ct_addr  output  8  ciphertext memory address; ct[0] = message length L, ct[1..L] = bytes.
REQ-010 ct_rddata  input  8  ciphertext read data, valid one cycle after ct_addr is presented.
REQ-011 pt_addr  output  8  plaintext memory address.
REQ-012 pt_wrdata  output  8  plaintext write data.
REQ-013 pt_wren  output  1  plaintext write enable.

Function
REQ-014 The block SHALL run the RC4 PRGA over an S-box already initialised and key-scheduled upstream, decrypting ct into pt in length-prefixed format: pt[0]=L, pt[k]=ct[k] XOR pad_k for k=1..L.
REQ-015 The algorithm SHALL be: i=0, j=0; for k=1..L: i=(i+1) mod 256; j=(j+S[i]) mod 256; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256].
REQ-016 All index arithmetic SHALL be 8-bit with natural wrap-around; carries are discarded.
REQ-017 The handshake SHALL work as follows: en=1 and rdy=1 at a rising edge starts a run, and rdy SHALL be 0 from the next cycle until completion.
REQ-018 en SHALL be ignored while rdy=0.
REQ-019 If en is still high when rdy returns to 1, a new run SHALL start on that edge.
REQ-020 States SHALL be IDLE, LEN, LENW, RI, RJ, WI, WJ, RP, WP, one cycle each.
REQ-021 State actions:
- IDLE: rdy=1.
- LEN: ct_addr=0.
- LENW: latch L=ct_rddata; write pt[0]=L; i=0, j=0, k=1.
- RI: s_addr=i+1; i<=i+1.
- RJ: si<=s_rddata; s_addr=j+s_rddata; j<=j+s_rddata.
- WI: sj<=s_rddata; write S[i]=s_rddata.
- WJ: write S[j]=si; ct_addr=k.
- RP: s_addr=si+sj.
- WP: write pt[k]=s_rddata XOR ct_rddata.
REQ-022 Transitions SHALL be: IDLE->LEN on accepted en; LEN->LENW; LENW->IDLE if L=0, else ->RI; RI->RJ->WI->WJ->RP->WP; WP->IDLE if k=L, else k<=k+1 and ->RI.
REQ-023 Latency: rdy SHALL reassert exactly 2+6*L cycles after the accepting edge (L=0: 2 cycles; L=255: 1532 cycles).
REQ-024 When i=j, the swap SHALL leave S[i] unchanged, and pad SHALL use the registered si+sj.
REQ-025 ct_addr SHALL hold k from WJ through WP, so ct_rddata is valid in WP.
REQ-026 In every state without a defined access, s_wren and pt_wren SHALL be 0 and all addresses and write data SHALL be 0.
REQ-027 Exactly one S write SHALL occur in each of WI and WJ, and exactly one pt write in each of LENW and WP; no other writes SHALL occur.

Reset
REQ-028 rst=1 SHALL force IDLE at the next edge, with rdy=1, s_wren=0, pt_wren=0, all addresses 0, and i, j, k, L, si, sj = 0.
REQ-029 Reset mid-run SHALL abort the run at that edge without completing the current write; memory contents are not restored.
REQ-030 rst SHALL take priority over en on the same edge.

Verification
REQ-031 Assert rst for 3 cycles -> rdy=1, s_wren=0, pt_wren=0, state IDLE.
REQ-032 S[x]=x, ct={0x01,0x41}, pulse en -> pt[0]=0x01, pt[1]=0x43 (pad=S[2]=0x02), S unchanged, rdy returns after 8 cycles.
REQ-033 ct[0]=0x00 -> pt[0]=0x00, no S writes, rdy returns after 2 cycles.
REQ-034 Key-scheduled S for key 0x000018 and a 53-byte ct -> pt and final S match the software RC4 model byte-for-byte, and rdy returns after 320 cycles.
REQ-035 en pulsed mid-run -> no effect and latency unchanged; en held high continuously -> back-to-back runs with exactly one rdy=1 cycle between them.
REQ-036 rst asserted in WI of byte 3 -> rdy=1 next cycle and no further writes; a fresh en then completes normally with L+1 pt writes.
